// File: rtl/rf_wb_arbiter_pkg.sv
// Shared core constants for the writeback path.
// Holds the requester indices, the default requester count and the
// register-address / data widths used by the writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int REG_AW  = 5;
  localparam int DATA_W  = 32;
  localparam int WB_NREQ = 3;

  localparam int REQ_EXU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_CSR = 2;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant.
// Ports:
//   req  [N-1:0]  request vector
//   ptr  [PW-1:0] index at which the search starts
//   gnt  [N-1:0]  one-hot grant, all-zero when no request is set
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin writeback arbiter in front of the register file,
// plus a per-register busy scoreboard for the issue stage.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready [NREQ]  per-requester handshake (ready is one-hot or zero)
//   req_waddr [5*NREQ]          destination register per requester
//   req_wdata [32*NREQ]         write data per requester
//   rf_wen/rf_waddr/rf_wdata    registered register-file write port
//   iss_valid, iss_rd           issue-stage claim of a destination register
//   chk_rs1/chk_rs2             source registers queried by issue
//   rs1_busy/rs2_busy           source has a write still pending
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = WB_NREQ
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [REG_AW*NREQ-1:0]   req_waddr,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  output logic                     rf_wen,
  output logic [REG_AW-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic                     iss_valid,
  input  logic [REG_AW-1:0]        iss_rd,
  input  logic [REG_AW-1:0]        chk_rs1,
  input  logic [REG_AW-1:0]        chk_rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     rr_ptr;
  logic [NREQ-1:0]   grant;
  logic              xfer_p0;
  logic [PW-1:0]     gidx_p0;
  logic [REG_AW-1:0] waddr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [31:0]       busy;
  logic [31:0]       set_mask;
  logic [31:0]       clr_mask;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == PW'(NREQ - 1)) ? '0 : v + PW'(1);
  endfunction

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (grant)
  );

  // Grants are suppressed during reset so nothing can be accepted then.
  assign req_ready = rst ? '0 : grant;

  // ---- p0: accept stage, select the granted requester's payload ----
  always_comb begin
    xfer_p0  = 1'b0;
    gidx_p0  = '0;
    waddr_p0 = '0;
    wdata_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        xfer_p0  = 1'b1;
        gidx_p0  = PW'(i);
        waddr_p0 = req_waddr[REG_AW*i +: REG_AW];
        wdata_p0 = req_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // Clear is applied before set, so a same-cycle set on the same register wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && (iss_rd != '0))
      set_mask[iss_rd] = 1'b1;
    if (xfer_p0 && (waddr_p0 != '0))
      clr_mask[waddr_p0] = 1'b1;
  end

  // ---- p1: register-file write port and scoreboard state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
      if (xfer_p0) begin
        rr_ptr   <= wrap_inc(gidx_p0);
        // x0 writes are consumed but never reach the register file.
        rf_wen   <= (waddr_p0 != '0);
        rf_waddr <= waddr_p0;
        rf_wdata <= wdata_p0;
      end else begin
        rf_wen <= 1'b0;
      end
    end
  end

  assign rs1_busy = (chk_rs1 != '0) && busy[chk_rs1];
  assign rs2_busy = (chk_rs2 != '0) && busy[chk_rs2];

  // Issuing to a register that already has a pending write is an issuer bug.
  always_ff @(posedge clk) begin
    if (!rst && iss_valid && (iss_rd != '0))
      assert (!busy[iss_rd])
        else $error("issue to already-busy register x%0d", iss_rd);
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [5*N-1:0]  req_waddr;
  logic [32*N-1:0] req_wdata;
  logic          rf_wen;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          iss_valid;
  logic [4:0]    iss_rd;
  logic [4:0]    chk_rs1, chk_rs2;
  logic          rs1_busy, rs2_busy;

  rf_wb_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          busy_m[32];
  int          ptr_m;
  logic        e_wen;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr_m + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
    ptr_m   = 0;
    e_wen   = 1'b0;
    e_waddr = '0;
    e_wdata = '0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]       = v;
    req_waddr[5*i +: 5]   = a;
    req_wdata[32*i +: 32] = d;
  endtask

  // One clock cycle: check combinational outputs against the model, take the
  // edge, advance the model, then check the registered write port.
  task automatic step(input string tag);
    int g;
    logic [4:0] a;
    g = rst ? -1 : model_grant();
    #1;
    check({tag, ".ready"}, 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    check({tag, ".rs1"}, 32'(rs1_busy), 32'((chk_rs1 != 0) && busy_m[chk_rs1]));
    check({tag, ".rs2"}, 32'(rs2_busy), 32'((chk_rs2 != 0) && busy_m[chk_rs2]));
    @(posedge clk);
    if (g >= 0) begin
      a       = req_waddr[5*g +: 5];
      e_wen   = (a != 0);
      e_waddr = a;
      e_wdata = req_wdata[32*g +: 32];
      ptr_m   = (g + 1) % N;
      if (a != 0) busy_m[a] = 1'b0;
    end else begin
      e_wen = 1'b0;
    end
    if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1'b1;
    #1;
    check({tag, ".wen"},   32'(rf_wen),   32'(e_wen));
    check({tag, ".waddr"}, 32'(rf_waddr), 32'(e_waddr));
    check({tag, ".wdata"}, rf_wdata,      e_wdata);
  endtask

  initial begin
    int rd;
    req_valid = '0; req_waddr = '0; req_wdata = '0;
    iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
    model_reset();

    // Reset state, requests ignored while in reset
    @(posedge clk); #1;
    check("rst.wen",   32'(rf_wen),   0);
    check("rst.waddr", 32'(rf_waddr), 0);
    check("rst.wdata", rf_wdata,      0);
    req_valid = 3'b111;
    #1;
    check("rst.ready", 32'(req_ready), 0);
    rst = 1'b0;

    // All three requesters valid: grants 0,1,2 in order
    for (int k = 0; k < 3; k++) begin
      set_req(k, 1'b1, 5'(k + 1), 32'h1111_0000 + k);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rr.gnt", 32'(req_ready), 32'd1 << k);
      step("rr");
      check("rr.wen1", 32'(rf_wen), 1);
      check("rr.addr", 32'(rf_waddr), k + 1);
      check("rr.data", rf_wdata, 32'h1111_0000 + k);
    end
    req_valid = '0;
    step("idle");
    check("idle.wen0",  32'(rf_wen), 0);
    check("idle.hold",  32'(rf_waddr), 3);

    // LSU only
    set_req(REQ_LSU, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("lsu.ready", 32'(req_ready), 3'b010);
    step("lsu");
    check("lsu.wen",   32'(rf_wen), 1);
    check("lsu.waddr", 32'(rf_waddr), 5);
    check("lsu.wdata", rf_wdata, 32'hDEADBEEF);
    req_valid = '0;

    // EXU write to x0: accepted, pointer advances, no RF write
    set_req(REQ_EXU, 1'b1, 5'd0, 32'h5555_5555);
    #1;
    check("x0.ready", 32'(req_ready), 3'b001);
    step("x0");
    check("x0.wen", 32'(rf_wen), 0);
    set_req(REQ_EXU, 1'b1, 5'd4, 32'h4444);
    set_req(REQ_LSU, 1'b1, 5'd6, 32'h6666);
    #1;
    check("x0.ptr1", 32'(req_ready), 3'b010);
    step("x0.next");
    req_valid = '0;

    // Busy set by issue, cleared by writeback
    iss_valid = 1'b1; iss_rd = 5'd7;
    step("iss7");
    iss_valid = 1'b0; chk_rs1 = 5'd7;
    #1;
    check("sb.rs1set", 32'(rs1_busy), 1);
    set_req(REQ_LSU, 1'b1, 5'd7, 32'h0000_00A7);
    step("wb7");
    check("sb.rs1clr", 32'(rs1_busy), 0);
    req_valid = '0;

    // Same-cycle set and clear of x9: set wins
    iss_valid = 1'b1; iss_rd = 5'd9;
    set_req(REQ_CSR, 1'b1, 5'd9, 32'h99);
    step("setclr9");
    iss_valid = 1'b0; req_valid = '0;
    chk_rs2 = 5'd9;
    #1;
    check("sb.x9busy", 32'(rs2_busy), 1);
    chk_rs2 = 5'd0;
    #1;
    check("sb.rs2x0", 32'(rs2_busy), 0);

    // Randomized traffic against the model
    repeat (300) begin
      req_valid = 3'($urandom);
      for (int k = 0; k < N; k++) begin
        req_waddr[5*k +: 5]   = 5'($urandom_range(0, 31));
        req_wdata[32*k +: 32] = $urandom;
      end
      rd = $urandom_range(0, 31);
      iss_rd    = 5'(rd);
      iss_valid = ($urandom_range(0, 1) == 1) && !(rd != 0 && busy_m[rd]);
      chk_rs1 = 5'($urandom_range(0, 31));
      chk_rs2 = 5'($urandom_range(0, 31));
      step("rnd");
    end

    // Reset asserted between edges with a write in flight
    req_valid = '0; iss_valid = 1'b0;
    rd = 1;
    while (rd < 31 && busy_m[rd]) rd++;
    iss_valid = !busy_m[rd]; iss_rd = 5'(rd);
    set_req(0, 1'b1, 5'd10, 32'hA0A0_0010);
    set_req(1, 1'b1, 5'd11, 32'hA0A0_0011);
    set_req(2, 1'b1, 5'd13, 32'hA0A0_0013);
    step("pre_rst");
    iss_valid = 1'b0;
    chk_rs1 = 5'(rd);
    #1;
    check("mid.wen_before",  32'(rf_wen), 1);
    check("mid.busy_before", 32'(rs1_busy), 32'(busy_m[rd]));
    #1;
    rst = 1'b1;
    #1;
    check("mid.wen",   32'(rf_wen), 0);
    check("mid.waddr", 32'(rf_waddr), 0);
    check("mid.wdata", rf_wdata, 0);
    check("mid.ready", 32'(req_ready), 0);
    check("mid.busy",  32'(rs1_busy), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("post.gnt0", 32'(req_ready), 3'b001);
    step("post");
    check("post.waddr", 32'(rf_waddr), 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of writeback requesters (0 = EXU, 1 = LSU, 2 = CSR).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  NREQ  per-requester write request.
REQ-005 SHALL have port req_ready  output  NREQ  per-requester accept, one-hot or zero.
REQ-006 SHALL have port req_waddr  input  5*NREQ  destination register; requester i occupies bits [5i+4:5i].
REQ-007 SHALL have port req_wdata  input  32*NREQ  write data; requester i occupies bits [32i+31:32i].
REQ-008 SHALL have port rf_wen, rf_waddr, rf_wdata  output  1/5/32  register-file write port, registered.
REQ-009 SHALL have port iss_valid, iss_rd  input  1/5  issue-stage claim of a destination register.
REQ-010 SHALL have port chk_rs1, chk_rs2  input  5/5  source registers to check.
REQ-011 SHALL have port rs1_busy, rs2_busy  output  1/1  source has a pending write.

Function
REQ-012 SHALL arbitrate round-robin: search starts at pointer rr_ptr; the first requester with req_valid high is granted.
REQ-013 SHALL drive req_ready combinationally, high only for the granted requester, and all-zero when no req_valid is high.
REQ-014 SHALL define a transfer as req_valid[i] & req_ready[i]; at most one transfer occurs per cycle.
REQ-015 SHALL set rr_ptr to (granted index + 1) mod NREQ on each transfer, and hold it otherwise.
REQ-016 SHALL present a transfer on rf_wen/rf_waddr/rf_wdata exactly one cycle after acceptance.
REQ-017 SHALL accept a transfer with waddr = 0 normally (ready high, rr_ptr advances) but keep rf_wen at 0 for it.
REQ-018 SHALL drive rf_wen at 0 in any cycle that follows a cycle with no transfer; rf_waddr/rf_wdata hold their last values.
REQ-019 SHALL keep a 32-bit busy vector; iss_valid with iss_rd != 0 sets busy[iss_rd] at the clock edge.
REQ-020 SHALL clear busy[waddr] at the edge of an accepted transfer with waddr != 0.
REQ-021 SHALL give set priority when a set and a clear target the same register in one cycle (busy remains 1).
REQ-022 SHALL compute rsN_busy = busy[chk_rsN] combinationally, forced to 0 when chk_rsN = 0.
REQ-023 SHALL treat iss_valid to an already-busy register as an issuer error: busy stays 1, flagged by a simulation assertion.
REQ-024 SHALL hold busy[0] constantly at 0.

Reset
REQ-025 SHALL, while rst is high and asynchronously, force rr_ptr = 0, busy = 0, rf_wen = 0, rf_waddr = 0, rf_wdata = 0.
REQ-026 SHALL drive req_ready all-zero while rst is high; a transfer in flight when rst asserts is discarded.
REQ-027 SHALL resume arbitration from requester 0 on the first edge after rst deasserts.

Structure
REQ-028 SHALL take the requester index constants (REQ_EXU = 0, REQ_LSU = 1, REQ_CSR = 2), NREQ and the register-address width of 5 from the shared core package.
REQ-029 SHALL implement the round-robin grant logic as one sub-module, rr_arbiter (inputs: request vector and pointer; output: one-hot grant).
REQ-030 SHALL contain no other sub-modules; the register file itself stays external.

Verification
REQ-031 Bench SHALL cover: after reset, all three req_valid held high for 3 cycles -> grants 0, 1, 2 in order; rf_wen high on cycles 2–4 with matching data.
REQ-032 Bench SHALL cover: only LSU valid, waddr = 5, wdata = 0xDEADBEEF -> req_ready = 3'b010, next cycle rf_wen = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF.
REQ-033 Bench SHALL cover: EXU write to x0 -> ready high, rr_ptr moves to 1, rf_wen stays 0.
REQ-034 Bench SHALL cover: iss_valid, iss_rd = 7, then chk_rs1 = 7 -> rs1_busy = 1; after an accepted write to x7 -> rs1_busy = 0 the next cycle.
REQ-035 Bench SHALL cover: set and clear of x9 in the same cycle -> busy[9] remains 1; chk_rs2 = 0 -> rs2_busy = 0 always.
REQ-036 Bench SHALL cover: rst asserted mid-transfer (between edges) -> rf_wen, busy and req_ready go to 0 immediately, and the next grant after release goes to requester 0.
